scan_display_4dig: RTL

Four-digit time-multiplexed display scanner, immediately upstream of the 7-segment decoder. Holds a 4-digit BCD value and cycles through the digits at a programmable rate. On each step it drives one BCD nibble on `data` to the decoder and a one-hot digit enable on `dig_sel` to the display common lines. New values are double-buffered and applied only at frame boundaries, so the display never shows a mix of old and new digits.

---
 rtl/scan_pkg.sv | 26 ++
 rtl/scan_prescaler.sv | 32 +++
 rtl/scan_display_4dig.sv | 97 +++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the four-digit display scanner.
// Optional feature macro: SCAN_LZB_EN (leading-zero blanking helper).
package scan_pkg;

    // Code that the downstream 7-segment decoder renders as an unlit digit.
    localparam logic [3:0] BLANK_CODE = 4'b1111;

    // Number of digits on the display.
    localparam int NDIG = 4;

    // One-hot digit enable for a 2-bit digit index.
    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

`ifdef SCAN_LZB_EN
    // Digit k (k >= 1) is blanked when it and every more significant
    // nibble are zero; digit 0 always shows so a value of 0 reads "0".
    function automatic logic lzb_blank(input logic [15:0] value, input logic [1:0] k);
        logic [15:0] upper;
        upper = value >> {k, 2'b00};
        return (k != 2'd0) && (upper == 16'h0000);
    endfunction
`endif

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the last count of each slot.
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A one-bit counter is kept even for DIV=1 so the design stays legal.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick on the last count of the slot and wrap back to zero there.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_display_4dig.sv
// Four-digit time-multiplexed display scanner feeding a 7-segment decoder.
// New values are double-buffered and only take effect at frame start.
// Optional feature macro: SCAN_LZB_EN (leading-zero blanking).
module scan_display_4dig #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        load,
    output logic [3:0]  data,
    output logic [3:0]  dig_sel,
    output logic        frame_done
);

    import scan_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(NDIG - 1);

    logic        tick;
    logic        frame_start;
    logic [15:0] eff;
    logic [3:0]  nibble;
    logic [3:0]  slot_code;

    logic [15:0] pend_q, pend_d;
    logic [15:0] disp_q, disp_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  data_q, data_d;
    logic [3:0]  dig_sel_q, dig_sel_d;
    logic        frame_done_q, frame_done_d;

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Double buffer: capture loads, and at frame start promote the pending
    // value (forwarding a same-cycle load) so a frame never mixes values.
    always_comb begin
        pend_d      = load ? digits : pend_q;
        frame_start = tick && (idx_q == 2'd0);
        eff         = frame_start ? pend_d : disp_q;
        disp_d      = frame_start ? pend_d : disp_q;
    end

    // Select the nibble for the digit being stepped to, blanking if enabled.
    always_comb begin
        nibble = eff[{idx_q, 2'b00} +: 4];
`ifdef SCAN_LZB_EN
        slot_code = lzb_blank(eff, idx_q) ? BLANK_CODE : nibble;
`else
        slot_code = nibble;
`endif
    end

    // Advance the scan on each tick; outputs hold between ticks.
    always_comb begin
        data_d       = data_q;
        dig_sel_d    = dig_sel_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        if (tick) begin
            dig_sel_d    = onehot4(idx_q);
            data_d       = slot_code;
            idx_d        = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
            frame_done_d = (idx_q == LAST_IDX);
        end
    end

    // State and registered outputs; display starts dark and blank.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= 16'h0000;
            disp_q       <= 16'h0000;
            idx_q        <= 2'd0;
            data_q       <= BLANK_CODE;
            dig_sel_q    <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data       = data_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule
